// File: rtl/pulse_gen_pkg.sv
// Shared phase encoding, mode constants and sizing helpers for the trapezoid pulse generator.
package pulse_gen_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      RISE  = 3'd2,
      HIGH  = 3'd3,
      FALL  = 3'd4,
      LOW   = 3'd5
   } phase_t;

   localparam logic [1:0] MODE_ONESHOT  = 2'd0;
   localparam logic [1:0] MODE_PERIODIC = 2'd1;
   localparam logic [1:0] MODE_BURST    = 2'd2;

   // Accumulator width: (W+1)-bit step times up to 2^(2^SHW-1) cycles.
   function automatic int ramp_acc_w(input int w, input int shw);
      return w + (1 << shw);
   endfunction

endpackage

// File: rtl/pulse_ramp.sv
// Linear interpolator shared by RISE and FALL: level = base + (step_total >>> sh).
// level is combinational on the accumulator's next value so the parent can register it.
module pulse_ramp
   import pulse_gen_pkg::*;
#(
   parameter int W   = 16,
   parameter int SHW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [W-1:0]  base,
   input  logic signed [W-1:0]  target,
   input  logic [SHW-1:0]       sh,
   input  logic                 clear,
   input  logic                 step,
   output logic signed [W-1:0]  level
);

   localparam int AW = ramp_acc_w(W, SHW);

   logic signed [W:0]    d;
   logic signed [AW-1:0] d_x;
   logic signed [AW-1:0] base_x;
   logic signed [AW-1:0] acc_reg;
   logic signed [AW-1:0] acc_next;
   logic signed [AW-1:0] sum;

   assign d      = $signed({target[W-1], target}) - $signed({base[W-1], base});
   assign d_x    = $signed({{(AW-W-1){d[W]}}, d});
   assign base_x = $signed({{(AW-W){base[W-1]}}, base});

   always_comb begin
      acc_next = acc_reg;
      if (clear)
         acc_next = '0;
      else if (step)
         acc_next = acc_reg + d_x;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_reg <= '0;
      else
         acc_reg <= acc_next;
   end

   // Result always lies between base and target, so the low W bits are exact.
   assign sum   = (acc_next >>> sh) + base_x;
   assign level = sum[W-1:0];

endmodule

// File: rtl/trapezoid_pulse_gen.sv
// Trapezoidal pulse generator: delay, linear rise, high, linear fall, low;
// oneshot, periodic or counted-burst operation with abort and done reporting.
module trapezoid_pulse_gen
   import pulse_gen_pkg::*;
#(
   parameter int W   = 16,
   parameter int TW  = 24,
   parameter int SHW = 4,
   parameter int BW  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [1:0]           mode,
   input  logic signed [W-1:0]  iv,
   input  logic signed [W-1:0]  pv,
   input  logic [TW-1:0]        t_delay,
   input  logic [SHW-1:0]       rise_sh,
   input  logic [TW-1:0]        t_high,
   input  logic [SHW-1:0]       fall_sh,
   input  logic [TW-1:0]        t_low,
   input  logic [BW-1:0]        burst_n,
   output logic signed [W-1:0]  out_val,
   output logic [2:0]           phase,
   output logic                 busy,
   output logic                 done,
   output logic [BW-1:0]        pulse_cnt
);

   localparam int RW = (1 << SHW) - 1;
   localparam int CW = (TW > RW) ? TW : RW;

   phase_t              state_reg, state_next;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic [BW-1:0]       pcnt_reg, pcnt_next;
   logic                done_reg, done_next;
   logic signed [W-1:0] out_reg, out_next;

   logic [1:0]          mode_reg;
   logic signed [W-1:0] iv_reg, pv_reg;
   logic [TW-1:0]       t_delay_reg, t_high_reg, t_low_reg;
   logic [SHW-1:0]      rise_sh_reg, fall_sh_reg;
   logic [BW-1:0]       burst_n_reg;

   // Effective config: the inputs on the accepting edge, the shadow copy otherwise.
   logic                accept;
   logic [1:0]          c_mode;
   logic signed [W-1:0] c_iv, c_pv;
   logic [TW-1:0]       c_t_delay, c_t_high, c_t_low;
   logic [SHW-1:0]      c_rise_sh, c_fall_sh;
   logic [BW-1:0]       c_burst_n, burst_eff;

   logic                enter, go_chain, go_after_rise, go_after_high, go_eop, zero_pulse;
   logic [BW-1:0]       pcnt_base, pcnt_inc;
   logic                ramp_clear, ramp_step;
   logic signed [W-1:0] ramp_base, ramp_target, ramp_level;
   logic [SHW-1:0]      ramp_sh;

   function automatic logic [CW-1:0] timer_load(input logic [TW-1:0] n);
      return (n == '0) ? '0 : CW'(n - 1'b1);
   endfunction

   function automatic logic [CW-1:0] ramp_load(input logic [SHW-1:0] sh);
      logic [CW-1:0] one;
      one = CW'(1);
      return (one << sh) - 1'b1;
   endfunction

   assign accept    = (state_reg == IDLE) && start && !stop;
   assign c_mode    = accept ? mode    : mode_reg;
   assign c_iv      = accept ? iv      : iv_reg;
   assign c_pv      = accept ? pv      : pv_reg;
   assign c_t_delay = accept ? t_delay : t_delay_reg;
   assign c_t_high  = accept ? t_high  : t_high_reg;
   assign c_t_low   = accept ? t_low   : t_low_reg;
   assign c_rise_sh = accept ? rise_sh : rise_sh_reg;
   assign c_fall_sh = accept ? fall_sh : fall_sh_reg;
   assign c_burst_n = accept ? burst_n : burst_n_reg;
   assign burst_eff = (c_burst_n == '0) ? BW'(1) : c_burst_n;
   assign zero_pulse = (c_rise_sh == '0) && (c_t_high == '0) && (c_fall_sh == '0);

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      pcnt_next     = pcnt_reg;
      done_next     = 1'b0;
      enter         = 1'b0;
      go_chain      = 1'b0;
      go_after_rise = 1'b0;
      go_after_high = 1'b0;
      go_eop        = 1'b0;
      pcnt_base     = accept ? '0 : pcnt_reg;
      pcnt_inc      = (pcnt_base == '1) ? pcnt_base : pcnt_base + 1'b1;
      if (accept)
         pcnt_next = '0;

      case (state_reg)
         IDLE: if (accept) begin
            if (c_t_delay != '0) begin
               state_next = DELAY;
               enter      = 1'b1;
            end else
               go_chain = 1'b1;
         end
         DELAY: if (cnt_reg == '0) go_chain      = 1'b1; else cnt_next = cnt_reg - 1'b1;
         RISE:  if (cnt_reg == '0) go_after_rise = 1'b1; else cnt_next = cnt_reg - 1'b1;
         HIGH:  if (cnt_reg == '0) go_after_high = 1'b1; else cnt_next = cnt_reg - 1'b1;
         FALL:  if (cnt_reg == '0) go_eop        = 1'b1; else cnt_next = cnt_reg - 1'b1;
         LOW:   if (cnt_reg == '0) go_chain      = 1'b1; else cnt_next = cnt_reg - 1'b1;
         default: state_next = IDLE;
      endcase

      // Skipped phases chain forward on the same edge.
      if (go_chain) begin
         if (c_rise_sh != '0) begin
            state_next = RISE;
            enter      = 1'b1;
         end else
            go_after_rise = 1'b1;
      end
      if (go_after_rise) begin
         if (c_t_high != '0) begin
            state_next = HIGH;
            enter      = 1'b1;
         end else
            go_after_high = 1'b1;
      end
      if (go_after_high) begin
         if (c_fall_sh != '0) begin
            state_next = FALL;
            enter      = 1'b1;
         end else
            go_eop = 1'b1;
      end
      if (go_eop) begin
         pcnt_next = pcnt_inc;
         enter     = 1'b1;
         if (!(c_mode == MODE_PERIODIC || (c_mode == MODE_BURST && pcnt_inc != burst_eff))) begin
            state_next = IDLE;
            done_next  = 1'b1;
         // A zero-length pulse parks in LOW for at least one cycle to avoid a zero-time loop.
         end else if (c_t_low != '0 || zero_pulse)
            state_next = LOW;
         else if (c_rise_sh != '0)
            state_next = RISE;
         else if (c_t_high != '0)
            state_next = HIGH;
         else
            state_next = FALL;
      end

      if (enter) begin
         case (state_next)
            DELAY:   cnt_next = timer_load(c_t_delay);
            RISE:    cnt_next = ramp_load(c_rise_sh);
            HIGH:    cnt_next = timer_load(c_t_high);
            FALL:    cnt_next = ramp_load(c_fall_sh);
            LOW:     cnt_next = timer_load(c_t_low);
            default: cnt_next = '0;
         endcase
      end

      if (stop) begin
         state_next = IDLE;
         cnt_next   = '0;
         pcnt_next  = pcnt_reg;
         done_next  = 1'b0;
         enter      = 1'b0;
      end
   end

   assign ramp_clear  = enter;
   assign ramp_step   = !enter && (state_next == state_reg) &&
                        (state_reg == RISE || state_reg == FALL);
   assign ramp_base   = (state_next == FALL) ? c_pv : c_iv;
   assign ramp_target = (state_next == FALL) ? c_iv : c_pv;
   assign ramp_sh     = (state_next == FALL) ? c_fall_sh : c_rise_sh;

   pulse_ramp #(.W(W), .SHW(SHW)) u_ramp (
      .clk    (clk),
      .rst    (rst),
      .base   (ramp_base),
      .target (ramp_target),
      .sh     (ramp_sh),
      .clear  (ramp_clear),
      .step   (ramp_step),
      .level  (ramp_level)
   );

   always_comb begin
      out_next = c_iv;
      case (state_next)
         HIGH:       out_next = c_pv;
         RISE, FALL: out_next = ramp_level;
         default:    out_next = c_iv;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         pcnt_reg    <= '0;
         done_reg    <= 1'b0;
         out_reg     <= '0;
         mode_reg    <= '0;
         iv_reg      <= '0;
         pv_reg      <= '0;
         t_delay_reg <= '0;
         t_high_reg  <= '0;
         t_low_reg   <= '0;
         rise_sh_reg <= '0;
         fall_sh_reg <= '0;
         burst_n_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pcnt_reg  <= pcnt_next;
         done_reg  <= done_next;
         out_reg   <= out_next;
         if (accept) begin
            mode_reg    <= mode;
            iv_reg      <= iv;
            pv_reg      <= pv;
            t_delay_reg <= t_delay;
            t_high_reg  <= t_high;
            t_low_reg   <= t_low;
            rise_sh_reg <= rise_sh;
            fall_sh_reg <= fall_sh;
            burst_n_reg <= burst_n;
         end
      end
   end

   assign out_val   = out_reg;
   assign phase     = state_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign pulse_cnt = pcnt_reg;

endmodule

// File: tb/tb_trapezoid_pulse_gen.sv
// Directed, table-driven bench for trapezoid_pulse_gen plus hand-written multi-cycle sequences.
module tb_trapezoid_pulse_gen;

   localparam int P_I = 0, P_D = 1, P_R = 2, P_H = 3, P_F = 4, P_L = 5;

   logic               clk, rst, start, stop;
   logic [1:0]         mode;
   logic signed [15:0] iv, pv, out_val;
   logic [23:0]        t_delay, t_high, t_low;
   logic [3:0]         rise_sh, fall_sh;
   logic [7:0]         burst_n, pulse_cnt;
   logic [2:0]         phase;
   logic               busy, done;

   trapezoid_pulse_gen dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .iv(iv), .pv(pv), .t_delay(t_delay), .rise_sh(rise_sh), .t_high(t_high),
      .fall_sh(fall_sh), .t_low(t_low), .burst_n(burst_n),
      .out_val(out_val), .phase(phase), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit st, sp;
      int md, ivv, pvv, td, rs, th, fs, tl, bn;
      int e_out, e_ph, e_busy, e_done, e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   nchk = 0;
   int   nerr = 0;

   task automatic add(input bit st, input bit sp, input int md, input int ivv, input int pvv,
                      input int td, input int rs, input int th, input int fs, input int tl,
                      input int bn, input int e_out, input int e_ph, input int e_busy,
                      input int e_done, input int e_cnt);
      vec_t v;
      v = '{st, sp, md, ivv, pvv, td, rs, th, fs, tl, bn, e_out, e_ph, e_busy, e_done, e_cnt};
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      start   = v.st;
      stop    = v.sp;
      mode    = 2'(v.md);
      iv      = 16'(v.ivv);
      pv      = 16'(v.pvv);
      t_delay = 24'(v.td);
      rise_sh = 4'(v.rs);
      t_high  = 24'(v.th);
      fall_sh = 4'(v.fs);
      t_low   = 24'(v.tl);
      burst_n = 8'(v.bn);
   endtask

   task automatic run_row(input int idx, input vec_t v);
      drive(v);
      tick();
      $display("row %0d: st=%0b sp=%0b out=%0d phase=%0d busy=%0b done=%0b cnt=%0d",
               idx, v.st, v.sp, out_val, phase, busy, done, pulse_cnt);
      chk("out_val", longint'($signed(out_val)), v.e_out);
      chk("phase", longint'(phase), v.e_ph);
      chk("busy", longint'(busy), v.e_busy);
      chk("done", longint'(done), v.e_done);
      chk("pulse_cnt", longint'(pulse_cnt), v.e_cnt);
   endtask

   initial begin
      vec_t v;

      // Oneshot with delay and 4-cycle rise, instant fall
      add(1,0,0, 0,100,3,2,2,0,0,0,    0,P_D,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,    0,P_D,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,    0,P_D,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,    0,P_R,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,   25,P_R,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,   50,P_R,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,   75,P_R,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,  100,P_H,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,  100,P_H,1,0,0);
      add(0,0,0, 0,100,3,2,2,0,0,0,    0,P_I,0,1,1);
      add(0,0,0, 0,100,3,2,2,0,0,0,    0,P_I,0,0,1);
      // Burst of 3, negative pulse level, start clears pulse_cnt
      add(1,0,2, 5,-20,0,0,2,0,1,3,  -20,P_H,1,0,0);
      add(0,0,2, 5,-20,0,0,2,0,1,3,  -20,P_H,1,0,0);
      add(0,0,2, 5,-20,0,0,2,0,1,3,    5,P_L,1,0,1);
      add(0,0,2, 5,-20,0,0,2,0,1,3,  -20,P_H,1,0,1);
      add(0,0,2, 5,-20,0,0,2,0,1,3,  -20,P_H,1,0,1);
      add(0,0,2, 5,-20,0,0,2,0,1,3,    5,P_L,1,0,2);
      add(0,0,2, 5,-20,0,0,2,0,1,3,  -20,P_H,1,0,2);
      add(0,0,2, 5,-20,0,0,2,0,1,3,  -20,P_H,1,0,2);
      add(0,0,2, 5,-20,0,0,2,0,1,3,    5,P_I,0,1,3);
      add(0,0,2, 5,-20,0,0,2,0,1,3,    5,P_I,0,0,3);
      // Burst with burst_n=0 gives one pulse
      add(1,0,2, 5,-20,0,0,2,0,1,0,  -20,P_H,1,0,0);
      add(0,0,2, 5,-20,0,0,2,0,1,0,  -20,P_H,1,0,0);
      add(0,0,2, 5,-20,0,0,2,0,1,0,    5,P_I,0,1,1);
      // Rise then fall ramps with floor rounding on a negative step
      add(1,0,0, 0,-7,0,2,0,2,0,0,     0,P_R,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -2,P_R,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -4,P_R,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -6,P_R,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -7,P_F,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -6,P_F,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -4,P_F,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,    -2,P_F,1,0,0);
      add(0,0,0, 0,-7,0,2,0,2,0,0,     0,P_I,0,1,1);
      // Periodic, stop+start in 2nd HIGH cycle of pulse 2 (beats natural end)
      add(1,0,1, 3,40,0,0,2,0,1,0,    40,P_H,1,0,0);
      add(0,0,1, 3,40,0,0,2,0,1,0,    40,P_H,1,0,0);
      add(0,0,1, 3,40,0,0,2,0,1,0,     3,P_L,1,0,1);
      add(0,0,1, 3,40,0,0,2,0,1,0,    40,P_H,1,0,1);
      add(0,0,1, 3,40,0,0,2,0,1,0,    40,P_H,1,0,1);
      add(1,1,1, 3,40,0,0,2,0,1,0,     3,P_I,0,0,1);
      add(0,0,1, 3,40,0,0,2,0,1,0,     3,P_I,0,0,1);
      // Config changes and start while busy are ignored
      add(1,0,0, 0,20,1,0,3,0,0,0,     0,P_D,1,0,0);
      add(1,0,1, 0,99,1,0,3,0,0,0,    20,P_H,1,0,0);
      add(0,0,1, 0,99,1,0,3,0,0,0,    20,P_H,1,0,0);
      add(1,0,1, 0,99,1,0,3,0,0,0,    20,P_H,1,0,0);
      add(0,0,1, 0,99,1,0,3,0,0,0,     0,P_I,0,1,1);
      add(0,0,1, 0,99,1,0,3,0,0,0,     0,P_I,0,0,1);
      // Reserved mode behaves as oneshot
      add(1,0,3, 1,2,0,0,1,0,0,0,      2,P_H,1,0,0);
      add(0,0,3, 1,2,0,0,1,0,0,0,      1,P_I,0,1,1);

      // Reset state, observed while rst is held
      rst = 1'b1;
      v = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      drive(v);
      #2;
      chk("rst_out_val", longint'($signed(out_val)), 0);
      chk("rst_phase", longint'(phase), P_I);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_pulse_cnt", longint'(pulse_cnt), 0);
      tick();
      rst = 1'b0;

      foreach (vecs[i]) run_row(i, vecs[i]);

      // Periodic square wave: 4 high, 4 low, levels +/-50
      v = '{1,0,1,-50,50,0,0,4,0,4,0,0,0,0,0,0};
      drive(v);
      tick();
      start = 1'b0;
      for (int c = 0; c < 24; c++) begin
         $display("periodic cycle %0d: out=%0d cnt=%0d done=%0b", c, out_val, pulse_cnt, done);
         chk("periodic_out", longint'($signed(out_val)), ((c % 8) < 4) ? 50 : -50);
         chk("periodic_cnt", longint'(pulse_cnt), (c + 4) / 8);
         chk("periodic_done", longint'(done), 0);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      $display("periodic stop: out=%0d phase=%0d cnt=%0d", out_val, phase, pulse_cnt);
      chk("pstop_out", longint'($signed(out_val)), -50);
      chk("pstop_busy", longint'(busy), 0);
      chk("pstop_cnt", longint'(pulse_cnt), 3);

      // Back-to-back 1-cycle pulses saturate pulse_cnt at 255
      v = '{1,0,1,0,9,0,0,1,0,0,0,0,0,0,0,0};
      drive(v);
      tick();
      start = 1'b0;
      for (int c = 0; c < 300; c++) tick();
      $display("saturation: cnt=%0d busy=%0b out=%0d", pulse_cnt, busy, out_val);
      chk("sat_cnt", longint'(pulse_cnt), 255);
      chk("sat_busy", longint'(busy), 1);
      chk("sat_out", longint'($signed(out_val)), 9);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Asynchronous reset in the middle of a rise
      v = '{1,0,0,0,100,0,3,1,0,0,0,0,0,0,0,0};
      drive(v);
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre_rst_out", longint'($signed(out_val)), 25);
      rst = 1'b1;
      #1;
      $display("async reset: out=%0d phase=%0d busy=%0b", out_val, phase, busy);
      chk("arst_out", longint'($signed(out_val)), 0);
      chk("arst_phase", longint'(phase), P_I);
      chk("arst_busy", longint'(busy), 0);
      chk("arst_cnt", longint'(pulse_cnt), 0);
      tick();
      rst = 1'b0;
      run_row(1000, '{1,0,0,0,100,0,0,1,0,0,0, 100,P_H,1,0,0});
      run_row(1001, '{0,0,0,0,100,0,0,1,0,0,0,   0,P_I,0,1,1});

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
